adder_bist_checker: RTL and testbench
=====================================

# adder_bist_checker

Self-test controller that acts as the hardware counterpart of the carry-skip adder stimulus bench. It drives operand vectors into a combinational 16-bit adder under test and samples its `sum`/`cout` response. Each response is checked against an internal golden `a+b+cin`, with pass/fail, error count and the first failing vector reported. It sits beside any adder in the family, carry-skip included, for on-FPGA regression.

## Interface
- `WIDTH`, 16: adder operand width; legal range 4..16.
- `NUM_VECTORS`, 256: total vectors per run, including the 4 directed vectors; legal range 4..65535.
- `LFSR_SEED`, 32'hACE1_0001: nonzero LFSR seed.

Ports (reset is synchronous and active-high; one clock):
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: pulse that begins a run; honoured only in IDLE or DONE.
- `a`  out  WIDTH: operand A to the adder under test (registered).
- `b`  out  WIDTH: operand B to the adder under test (registered).
- `cin`  out  1: carry-in to the adder under test (registered).
- `sum`  in  WIDTH: adder under test sum (combinational from `a`/`b`/`cin`).
- `cout`  in  1: adder under test carry-out.
- `busy`  out  1: run in progress.
- `done`  out  1: run complete; held until next `start` or `rst`.
- `pass`  out  1: valid when `done`; 1 iff `err_count`==0.
- `err_count`  out  16: mismatching vectors, saturating at 16'hFFFF.
- `vec_count`  out  16: vectors compared so far.
- `fail_a`, `fail_b`  out  WIDTH: operands of the first mismatch.
- `fail_cin`  out  1: carry-in of the first mismatch.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE to RUN on `start`. RUN to DRAIN after the last vector is driven. DRAIN to DONE after the final compare. DONE to RUN on `start`.
- Vector sequence: index 0..3 are directed, then LFSR-generated.
  - Index 0: (0,0,1).
  - Index 1: (14,1,1).
  - Index 2: (5,0,0).
  - Index 3: (999 mod 2^WIDTH,0,1).
  - Index ≥4: 32-bit Galois LFSR with taps x^32+x^22+x^2+x+1. `a`=lfsr[WIDTH-1:0], `b`=lfsr[WIDTH+15:16], `cin`=lfsr[31]^lfsr[0]. The LFSR advances once per vector from 4 onward.
- Golden model: expected = a + b + cin computed at WIDTH+1 bits. Bit WIDTH is compared to `cout`; the low WIDTH bits are compared to `sum`.
- Each vector's drive operands are pipelined into an expected register alongside it. The compare happens the cycle after the drive.
- On mismatch:
  - `err_count` increments, unless already at 16'hFFFF.
  - If this is the first error, `fail_a`/`fail_b`/`fail_cin` latch the mismatching operands.
- `start` while in RUN or DRAIN is ignored.
- On a new `start` from DONE:
  - Counters and fail registers clear.
  - The LFSR reloads `LFSR_SEED`.
  - `done` drops.

## Timing
- Reset values:
  - `a`, `b`, `cin`, `busy`, `done`, `pass` are 0.
  - `err_count`, `vec_count`, `fail_*` are 0.
  - FSM is in IDLE and LFSR holds `LFSR_SEED`.
- Start to first vector: `start` sampled at edge T puts vector 0 on `a`/`b`/`cin` and raises `busy` after edge T.
- Throughput is one vector per cycle. Vector k is driven after edge T+k and compared at edge T+k+1.
- Completion:
  - The last compare occurs at edge T+NUM_VECTORS.
  - After edge T+NUM_VECTORS+1, `done`=1 and `busy`=0.
- In DONE, `pass`, `err_count` and `fail_*` are stable and `a`/`b`/`cin` hold the last vector.
- `rst` during RUN or DRAIN forces reset values at the next edge. No partial results survive.
- `start` and `rst` in the same cycle: `rst` wins.

## Structure
- A shared package `adder_bist_pkg` holds:
  - The FSM state enum.
  - The LFSR tap constant.
  - The 4-entry directed-vector table.
- Sub-module `bist_lfsr32`: seed load, enable-advance and 32-bit state output. It is instantiated once.
- Compare, counters and FSM stay in the top module.

## Test plan
- Correct adder, `NUM_VECTORS`=256: `start` → `done` at T+257, `pass`=1, `err_count`=0, `vec_count`=256.
- Directed vectors: probe `a`/`b`/`cin` over the first 4 cycles after `start` → (0,0,1), (14,1,1), (5,0,0), (999,0,1); the expected sums are 1, 16, 5 and 1000.
- `sum[3]` stuck-at-0 fault model: `start` → `pass`=0 and `err_count`>0. Vector 0 gives sum 1, bit 3 clear, so it passes. Vector 1 gives sum 16, bit 3 clear, so it passes. Vector 3 gives sum 1000 = 0x3E8, bit 3 set, so it fails. Result: `fail_a`=999, `fail_b`=0, `fail_cin`=1.
- `cout` tied to 0 with `a`=16'hFFFF forced via a directed-override bench adder → the first LFSR vector with a carry increments `err_count`. `err_count` saturation is checked with `NUM_VECTORS`=65535, `cout` inverted and `sum` corrupted → final `err_count`=16'hFFFF.
- `rst` asserted at T+100 → at the next edge all outputs reach reset values and the FSM is in IDLE. A subsequent `start` reproduces an identical vector sequence from `LFSR_SEED`.
- `start` re-pulsed at T+50 mid-run → ignored, `done` still at T+NUM_VECTORS+1. `start` in DONE → `done` drops and counters clear next cycle.

Source files
------------

// File: rtl/adder_bist_pkg.sv
// Shared definitions for the adder self-test controller: FSM states,
// LFSR feedback mask and the directed opening vectors.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam int NUM_DIRECTED = 4;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
    } vec_t;

    // Directed table; callers truncate operands to their own width
    function automatic vec_t directed_vec(input logic [1:0] idx);
        vec_t v;
        case (idx)
            2'd0:    v = {16'd0,   16'd0, 1'b1};
            2'd1:    v = {16'd14,  16'd1, 1'b1};
            2'd2:    v = {16'd5,   16'd0, 1'b0};
            default: v = {16'd999, 16'd0, 1'b1};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// 32-bit Galois LFSR with seed reload and enable-gated advance.
module bist_lfsr32
    import adder_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        en_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = SEED;
        end else if (en_i) begin
            state_d = state_q[0] ? ((state_q >> 1) ^ LFSR_TAPS) : (state_q >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/adder_bist_checker.sv
// Built-in self-test for a combinational adder: drives directed then LFSR
// vectors and checks each response one cycle later against a+b+cin.
module adder_bist_checker
    import adder_bist_pkg::*;
#(
    parameter int          WIDTH       = 16,
    parameter int          NUM_VECTORS = 256,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             cin,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      vec_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_cin
);

    localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] FIRST_RND = 16'(NUM_DIRECTED);

    state_e           state_q, state_d;
    logic [15:0]      idx_q, idx_d;
    logic [15:0]      drv_idx;
    logic             drive, clear, lfsr_en, cmp_q;
    logic [WIDTH-1:0] a_q, b_q, nxt_a, nxt_b;
    logic             cin_q, nxt_cin;
    logic [WIDTH:0]   exp_q;
    logic [15:0]      err_q, vec_q;
    logic [WIDTH-1:0] fail_a_q, fail_b_q;
    logic             fail_cin_q;
    logic [31:0]      lfsr_state;
    vec_t             dv;
    logic             mismatch;

    bist_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (clear),
        .en_i    (lfsr_en),
        .state_o (lfsr_state)
    );

    // The accepting start edge drives vector 0 itself, so idx_q already points past it
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drive   = 1'b0;
        clear   = 1'b0;
        lfsr_en = 1'b0;
        drv_idx = idx_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                    drive   = 1'b1;
                    drv_idx = 16'd0;
                    idx_d   = 16'd1;
                end
            end
            RUN: begin
                drive   = 1'b1;
                idx_d   = idx_q + 16'd1;
                lfsr_en = (idx_q >= FIRST_RND);
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!cmp_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        dv = directed_vec(drv_idx[1:0]);
        if (drv_idx >= FIRST_RND) begin
            nxt_a   = lfsr_state[WIDTH-1:0];
            nxt_b   = lfsr_state[WIDTH+15:16];
            nxt_cin = lfsr_state[31] ^ lfsr_state[0];
        end else begin
            nxt_a   = dv.a[WIDTH-1:0];
            nxt_b   = dv.b[WIDTH-1:0];
            nxt_cin = dv.cin;
        end
    end

    assign mismatch = ({cout, sum} != exp_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 16'd0;
            cmp_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            exp_q      <= '0;
            err_q      <= 16'd0;
            vec_q      <= 16'd0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_cin_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cmp_q   <= drive;
            if (drive) begin
                a_q   <= nxt_a;
                b_q   <= nxt_b;
                cin_q <= nxt_cin;
                exp_q <= {1'b0, nxt_a} + {1'b0, nxt_b} + {{WIDTH{1'b0}}, nxt_cin};
            end
            // a_q/b_q/cin_q still hold the vector being judged when cmp_q is set
            if (clear) begin
                err_q      <= 16'd0;
                vec_q      <= 16'd0;
                fail_a_q   <= '0;
                fail_b_q   <= '0;
                fail_cin_q <= 1'b0;
            end else if (cmp_q) begin
                vec_q <= vec_q + 16'd1;
                if (mismatch) begin
                    if (err_q != 16'hFFFF) begin
                        err_q <= err_q + 16'd1;
                    end
                    if (err_q == 16'd0) begin
                        fail_a_q   <= a_q;
                        fail_b_q   <= b_q;
                        fail_cin_q <= cin_q;
                    end
                end
            end
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign cin       = cin_q;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign pass      = done && (err_q == 16'd0);
    assign err_count = err_q;
    assign vec_count = vec_q;
    assign fail_a    = fail_a_q;
    assign fail_b    = fail_b_q;
    assign fail_cin  = fail_cin_q;

endmodule

// File: tb/tb_adder_bist_checker.sv
// Directed bench: a configurable faulty adder around one 256-vector checker,
// plus a second all-failing checker for the 65535-vector error-count ceiling.
module tb_adder_bist_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b, sum, err_count, vec_count, fail_a, fail_b;
    logic        cin, cout, busy, done, pass, fail_cin;
    logic [16:0] full;
    int          mode;

    logic        start2;
    logic [15:0] a2, b2, sum2, err2, vec2, fail_a2, fail_b2;
    logic        cin2, cout2, busy2, done2, pass2, fail_cin2;
    logic [16:0] full2;

    logic [15:0] ma [256];
    logic [15:0] mb [256];
    logic        mc [256];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // mode 0 correct, 1 sum[3] stuck-at-0, 2 cout tied low
    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        sum  = full[15:0];
        cout = full[16];
        if (mode == 1) sum[3] = 1'b0;
        else if (mode == 2) cout = 1'b0;
    end

    always_comb begin
        full2 = {1'b0, a2} + {1'b0, b2} + {16'd0, cin2};
        sum2  = full2[15:0] ^ 16'h0001;
        cout2 = ~full2[16];
    end

    adder_bist_checker #(.WIDTH(16), .NUM_VECTORS(256), .LFSR_SEED(32'hACE1_0001)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .sum(sum), .cout(cout), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .vec_count(vec_count),
        .fail_a(fail_a), .fail_b(fail_b), .fail_cin(fail_cin)
    );

    adder_bist_checker #(.WIDTH(16), .NUM_VECTORS(65535), .LFSR_SEED(32'hACE1_0001)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .sum(sum2), .cout(cout2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .vec_count(vec2),
        .fail_a(fail_a2), .fail_b(fail_b2), .fail_cin(fail_cin2)
    );

    task automatic build_model();
        logic [31:0] s;
        ma[0] = 16'd0;   mb[0] = 16'd0; mc[0] = 1'b1;
        ma[1] = 16'd14;  mb[1] = 16'd1; mc[1] = 1'b1;
        ma[2] = 16'd5;   mb[2] = 16'd0; mc[2] = 1'b0;
        ma[3] = 16'd999; mb[3] = 16'd0; mc[3] = 1'b1;
        s = 32'hACE1_0001;
        for (int k = 4; k < 256; k++) begin
            ma[k] = s[15:0];
            mb[k] = s[31:16];
            mc[k] = s[31] ^ s[0];
            s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, inout int n);
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a, b, cin, busy, done, pass} !== 36'd0) begin
            fails++;
            $display("[TB] FAIL reset_drive: got %h expected 0", {a, b, cin, busy, done, pass});
        end
        checks++;
        if ({err_count, vec_count} !== 32'd0) begin
            fails++;
            $display("[TB] FAIL reset_counts: got err=%h vec=%h expected 0", err_count, vec_count);
        end
        checks++;
        if ({fail_a, fail_b, fail_cin} !== 33'd0) begin
            fails++;
            $display("[TB] FAIL reset_fail_regs: got %h expected 0", {fail_a, fail_b, fail_cin});
        end
        rst = 1'b0;
    endtask

    task automatic test_directed_run();
        int          n;
        logic [15:0] exp_sum [4];
        exp_sum[0] = 16'd1; exp_sum[1] = 16'd16; exp_sum[2] = 16'd5; exp_sum[3] = 16'd1000;
        mode = 0;
        start_run();
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL busy_after_start: got %b expected 1", busy);
        end
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            checks++;
            if ({a, b, cin} !== {ma[k], mb[k], mc[k]}) begin
                fails++;
                $display("[TB] FAIL vector_%0d: got a=%0d b=%0d cin=%b expected a=%0d b=%0d cin=%b",
                         k, a, b, cin, ma[k], mb[k], mc[k]);
            end
            if (k < 4) begin
                checks++;
                if (sum !== exp_sum[k]) begin
                    fails++;
                    $display("[TB] FAIL directed_sum_%0d: got %0d expected %0d", k, sum, exp_sum[k]);
                end
            end
        end
        n = 5;
        wait_done(400, n);
        checks++;
        if (n !== 257 || done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL done_latency: got %0d cycles done=%b busy=%b expected 257 1 0", n, done, busy);
        end
        checks++;
        if ({pass, err_count, vec_count} !== {1'b1, 16'd0, 16'd256}) begin
            fails++;
            $display("[TB] FAIL clean_result: got pass=%b err=%0d vec=%0d expected 1 0 256", pass, err_count, vec_count);
        end
        checks++;
        if ({a, b, cin} !== {ma[255], mb[255], mc[255]}) begin
            fails++;
            $display("[TB] FAIL hold_last_vector: got %h expected %h", {a, b, cin}, {ma[255], mb[255], mc[255]});
        end
    endtask

    task automatic test_start_in_done();
        int n;
        mode = 0;
        start_run();
        checks++;
        if ({done, busy, err_count, vec_count} !== {1'b0, 1'b1, 32'd0}) begin
            fails++;
            $display("[TB] FAIL restart_clear: got done=%b busy=%b err=%0d vec=%0d expected 0 1 0 0",
                     done, busy, err_count, vec_count);
        end
        checks++;
        if ({a, b, cin} !== {16'd0, 16'd0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL restart_vector0: got %h expected %h", {a, b, cin}, {16'd0, 16'd0, 1'b1});
        end
        @(posedge clk); #1;
        checks++;
        if (vec_count !== 16'd1) begin
            fails++;
            $display("[TB] FAIL first_compare_count: got %0d expected 1", vec_count);
        end
        n = 1;
        wait_done(400, n);
        checks++;
        if (n !== 257 || pass !== 1'b1) begin
            fails++;
            $display("[TB] FAIL restart_run: got %0d cycles pass=%b expected 257 1", n, pass);
        end
    endtask

    task automatic test_stuck_sum3();
        int          n = 0;
        int          exp_err = 0;
        logic [16:0] tot;
        for (int k = 0; k < 256; k++) begin
            tot = {1'b0, ma[k]} + {1'b0, mb[k]} + {16'd0, mc[k]};
            if (tot[3]) exp_err++;
        end
        mode = 1;
        start_run();
        wait_done(400, n);
        checks++;
        if (n !== 257 || pass !== 1'b0 || err_count !== 16'(exp_err) || err_count == 16'd0) begin
            fails++;
            $display("[TB] FAIL stuck_sum3_count: got n=%0d pass=%b err=%0d expected 257 0 %0d",
                     n, pass, err_count, exp_err);
        end
        checks++;
        if ({fail_a, fail_b, fail_cin} !== {16'd999, 16'd0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL stuck_sum3_first: got a=%0d b=%0d cin=%b expected 999 0 1",
                     fail_a, fail_b, fail_cin);
        end
    endtask

    task automatic test_cout_zero();
        int          n = 0;
        int          exp_err = 0;
        int          first = -1;
        logic [16:0] tot;
        logic [32:0] exp_fail = 33'd0;
        for (int k = 0; k < 256; k++) begin
            tot = {1'b0, ma[k]} + {1'b0, mb[k]} + {16'd0, mc[k]};
            if (tot[16]) begin
                exp_err++;
                if (first < 0) begin
                    first = k;
                    exp_fail = {ma[k], mb[k], mc[k]};
                end
            end
        end
        mode = 2;
        start_run();
        wait_done(400, n);
        checks++;
        if (n !== 257 || err_count !== 16'(exp_err) || pass !== (exp_err == 0)) begin
            fails++;
            $display("[TB] FAIL cout_zero_count: got n=%0d err=%0d pass=%b expected 257 %0d", n, err_count, pass, exp_err);
        end
        checks++;
        if ({fail_a, fail_b, fail_cin} !== exp_fail) begin
            fails++;
            $display("[TB] FAIL cout_zero_first: got %h expected %h (vector %0d)", {fail_a, fail_b, fail_cin}, exp_fail, first);
        end
    endtask

    task automatic test_start_midrun();
        int n = 0;
        mode = 0;
        start_run();
        repeat (49) begin
            @(posedge clk); #1;
            n++;
        end
        start_run();
        n++;
        wait_done(400, n);
        checks++;
        if (n !== 257 || pass !== 1'b1 || vec_count !== 16'd256) begin
            fails++;
            $display("[TB] FAIL start_ignored_midrun: got n=%0d pass=%b vec=%0d expected 257 1 256", n, pass, vec_count);
        end
    endtask

    task automatic test_reset_midrun();
        int n = 0;
        mode = 1;
        start_run();
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        checks++;
        if ({a, b, cin, busy, done, pass} !== 36'd0 || {err_count, vec_count} !== 32'd0) begin
            fails++;
            $display("[TB] FAIL reset_midrun: got drive=%h err=%0d vec=%0d expected all 0",
                     {a, b, cin, busy, done, pass}, err_count, vec_count);
        end
        checks++;
        if ({fail_a, fail_b, fail_cin} !== 33'd0) begin
            fails++;
            $display("[TB] FAIL reset_midrun_fail_regs: got %h expected 0", {fail_a, fail_b, fail_cin});
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_stays_idle: got busy=%b expected 0", busy);
        end
        mode = 0;
        start_run();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            checks++;
            if ({a, b, cin} !== {ma[k], mb[k], mc[k]}) begin
                fails++;
                $display("[TB] FAIL replay_vector_%0d: got %h expected %h", k, {a, b, cin}, {ma[k], mb[k], mc[k]});
            end
        end
        n = 7;
        wait_done(400, n);
        checks++;
        if (n !== 257 || pass !== 1'b1) begin
            fails++;
            $display("[TB] FAIL replay_run: got n=%0d pass=%b expected 257 1", n, pass);
        end
    endtask

    task automatic test_saturation();
        int n = 0;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        while (!done2 && n < 70000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 65536 || err2 !== 16'hFFFF || vec2 !== 16'hFFFF || pass2 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL err_saturation: got n=%0d err=%h vec=%h pass=%b expected 65536 ffff ffff 0",
                     n, err2, vec2, pass2);
        end
        checks++;
        if ({fail_a2, fail_b2, fail_cin2} !== {16'd0, 16'd0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL sat_first_fail: got %h expected %h", {fail_a2, fail_b2, fail_cin2}, {16'd0, 16'd0, 1'b1});
        end
    endtask

    initial begin
        build_model();
        test_reset();
        test_directed_run();
        test_start_in_done();
        test_stuck_sum3();
        test_cout_zero();
        test_start_midrun();
        test_reset_midrun();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
